// File: rtl/pci_target_mem.sv
// PCI-style memory target: decodes the address phase, claims in-range memory
// read/write commands, and serves single or burst data phases from a word memory.
module pci_target_mem #(
  parameter logic [31:0] BASE_ADDR   = 32'h0000_1000,
  parameter int          DEPTH       = 16,
  parameter int          WAIT_STATES = 1
) (
  input  logic        clk,
  input  logic        rst_n,
  input  logic        frame,
  input  logic        irdy,
  input  logic [3:0]  cbe,
  input  logic [31:0] ad_in,
  output logic [31:0] ad_out,
  output logic        ad_oe,
  output logic        trdy,
  output logic        devsel
);

  localparam int          AW       = $clog2(DEPTH);
  localparam logic [32:0] END_ADDR = {1'b0, BASE_ADDR} + 33'(4 * DEPTH);
  localparam logic [2:0]  WS_WR    = 3'(WAIT_STATES);
  // Reads always need at least one turnaround cycle before driving data.
  localparam logic [2:0]  WS_RD    = (WAIT_STATES == 0) ? 3'd1 : 3'(WAIT_STATES);

  typedef enum logic [1:0] {IDLE, BUSY, WAIT, DATA} state_t;

  state_t         state_reg;
  logic [AW-1:0]  idx_reg;
  logic           is_read_reg;
  logic [2:0]     cnt_reg;

  logic           cmd_read;
  logic           cmd_hit;
  logic           in_range;
  logic [2:0]     load_val;
  logic           xfer;
  logic           wr_en;
  logic           abort;
  logic [AW-1:0]  idx_inc;
  logic [AW-1:0]  rd_idx;
  logic [31:0]    rd_word;

  assign cmd_read = (cbe == 4'b0110);
  assign cmd_hit  = cmd_read || (cbe == 4'b0111);
  assign in_range = ({1'b0, ad_in} >= {1'b0, BASE_ADDR}) && ({1'b0, ad_in} < END_ADDR);
  assign load_val = cmd_read ? WS_RD : WS_WR;
  assign xfer     = (state_reg == DATA) && !irdy && !trdy;
  assign wr_en    = xfer && !is_read_reg;
  assign abort    = frame && irdy;
  assign idx_inc  = idx_reg + AW'(1);
  // Entering DATA fetches the current word; each transfer prefetches the next.
  assign rd_idx   = (state_reg == DATA) ? idx_inc : idx_reg;

  generate
    for (genvar gi = 0; gi < 4; gi++) begin : g_lane
      logic [7:0] lane_mem [DEPTH];

      always_ff @(posedge clk) begin
        if (wr_en && !cbe[gi])
          lane_mem[idx_reg] <= ad_in[8*gi +: 8];
      end

      assign rd_word[8*gi +: 8] = lane_mem[rd_idx];
    end
  endgenerate

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state_reg   <= IDLE;
      idx_reg     <= '0;
      is_read_reg <= 1'b0;
      cnt_reg     <= '0;
      trdy        <= 1'b1;
      devsel      <= 1'b1;
      ad_oe       <= 1'b0;
      ad_out      <= '0;
    end else begin
      case (state_reg)
        IDLE: begin
          if (!frame) begin
            idx_reg     <= ad_in[AW+1:2];
            is_read_reg <= cmd_read;
            if (cmd_hit && in_range) begin
              devsel <= 1'b0;
              ad_oe  <= cmd_read;
              if (load_val == 3'd0) begin
                state_reg <= DATA;
                trdy      <= 1'b0;
              end else begin
                state_reg <= WAIT;
                cnt_reg   <= load_val;
              end
            end else begin
              state_reg <= BUSY;
            end
          end
        end
        BUSY: begin
          if (frame && irdy)
            state_reg <= IDLE;
        end
        WAIT: begin
          if (abort) begin
            state_reg <= IDLE;
            trdy      <= 1'b1;
            devsel    <= 1'b1;
            ad_oe     <= 1'b0;
          end else if (cnt_reg == 3'd1) begin
            state_reg <= DATA;
            trdy      <= 1'b0;
            if (is_read_reg)
              ad_out <= rd_word;
          end else begin
            cnt_reg <= cnt_reg - 3'd1;
          end
        end
        DATA: begin
          if (abort || (xfer && frame)) begin
            state_reg <= IDLE;
            trdy      <= 1'b1;
            devsel    <= 1'b1;
            ad_oe     <= 1'b0;
          end else if (xfer) begin
            idx_reg <= idx_inc;
            if (is_read_reg)
              ad_out <= rd_word;
          end
        end
        default: state_reg <= IDLE;
      endcase
    end
  end

endmodule

// File: tb/tb_pci_target_mem.sv
// Directed bench for pci_target_mem: single/burst writes and reads, wrap,
// initiator waits, foreign transactions and mid-burst reset.
module tb_pci_target_mem;

  logic        clk = 1'b0;
  logic        rst_n = 1'b0;
  logic        frame = 1'b1;
  logic        irdy = 1'b1;
  logic [3:0]  cbe = 4'hF;
  logic [31:0] ad_in = '0;
  logic [31:0] ad_out;
  logic        ad_oe;
  logic        trdy;
  logic        devsel;

  int n_checks = 0;
  int n_fail   = 0;

  pci_target_mem #(
    .BASE_ADDR  (32'h0000_1000),
    .DEPTH      (16),
    .WAIT_STATES(1)
  ) dut (
    .clk   (clk),
    .rst_n (rst_n),
    .frame (frame),
    .irdy  (irdy),
    .cbe   (cbe),
    .ad_in (ad_in),
    .ad_out(ad_out),
    .ad_oe (ad_oe),
    .trdy  (trdy),
    .devsel(devsel)
  );

  always #5 clk = ~clk;

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    n_checks++;
    assert (obs === exp) else begin
      n_fail++;
      $error("FAIL %s observed=%h expected=%h", tag, obs, exp);
    end
  endtask

  task automatic ctl(input string tag, input logic e_devsel, input logic e_trdy, input logic e_oe);
    check({tag, ".devsel"}, {31'd0, devsel}, {31'd0, e_devsel});
    check({tag, ".trdy"},   {31'd0, trdy},   {31'd0, e_trdy});
    check({tag, ".ad_oe"},  {31'd0, ad_oe},  {31'd0, e_oe});
  endtask

  task automatic drive(input logic f, input logic i, input logic [3:0] c, input logic [31:0] d);
    frame = f;
    irdy  = i;
    cbe   = c;
    ad_in = d;
  endtask

  task automatic bus_idle();
    drive(1'b1, 1'b1, 4'hF, 32'h0);
    tick();
  endtask

  task automatic single_write(input logic [31:0] addr, input logic [3:0] be, input logic [31:0] d);
    drive(1'b0, 1'b1, 4'b0111, addr);
    tick();
    drive(1'b1, 1'b0, be, d);
    tick();
    tick();
    bus_idle();
  endtask

  initial begin
    #12;
    ctl("reset", 1'b1, 1'b1, 1'b0);
    check("reset.ad_out", ad_out, 32'h0);
    rst_n = 1'b1;
    tick();

    // Single write to word 2
    drive(1'b0, 1'b1, 4'b0111, 32'h0000_1008);
    tick();
    ctl("wr1.addr+1", 1'b0, 1'b1, 1'b0);
    drive(1'b1, 1'b0, 4'b0000, 32'hDEAD_BEEF);
    tick();
    ctl("wr1.addr+2", 1'b0, 1'b0, 1'b0);
    tick();
    ctl("wr1.after", 1'b1, 1'b1, 1'b0);
    bus_idle();

    // Single read of word 2
    drive(1'b0, 1'b1, 4'b0110, 32'h0000_1008);
    tick();
    ctl("rd1.addr+1", 1'b0, 1'b1, 1'b1);
    drive(1'b1, 1'b0, 4'b0000, 32'h0);
    tick();
    ctl("rd1.addr+2", 1'b0, 1'b0, 1'b1);
    check("rd1.data", ad_out, 32'hDEAD_BEEF);
    tick();
    ctl("rd1.after", 1'b1, 1'b1, 1'b0);
    bus_idle();

    // Preload word 15 so the partial-byte write below has a known base
    single_write(32'h0000_103C, 4'b0000, 32'hAABB_CCDD);

    // Burst write words 14,15,0,1 (wraps); only byte 0 of word 15
    drive(1'b0, 1'b1, 4'b0111, 32'h0000_1038);
    tick();
    drive(1'b0, 1'b0, 4'b0000, 32'h1111_1111);
    tick();
    ctl("bw.first", 1'b0, 1'b0, 1'b0);
    tick();
    drive(1'b0, 1'b0, 4'b1110, 32'h2222_2222);
    tick();
    drive(1'b0, 1'b0, 4'b0000, 32'h3333_3333);
    tick();
    drive(1'b1, 1'b0, 4'b0000, 32'h4444_4444);
    tick();
    ctl("bw.after", 1'b1, 1'b1, 1'b0);
    bus_idle();

    // Burst read 14,15,0 with a 2-cycle initiator wait
    drive(1'b0, 1'b1, 4'b0110, 32'h0000_1038);
    tick();
    ctl("br.addr+1", 1'b0, 1'b1, 1'b1);
    drive(1'b0, 1'b0, 4'b0000, 32'h0);
    tick();
    check("br.w14", ad_out, 32'h1111_1111);
    tick();
    check("br.w15", ad_out, 32'hAABB_CC22);
    irdy = 1'b1;
    tick();
    check("br.wait1", ad_out, 32'hAABB_CC22);
    ctl("br.wait1", 1'b0, 1'b0, 1'b1);
    tick();
    check("br.wait2", ad_out, 32'hAABB_CC22);
    irdy = 1'b0;
    tick();
    check("br.w0", ad_out, 32'h3333_3333);
    frame = 1'b1;
    tick();
    ctl("br.after", 1'b1, 1'b1, 1'b0);
    bus_idle();

    // Foreign transaction: out of range address
    drive(1'b0, 1'b1, 4'b0110, 32'h0000_2000);
    tick();
    ctl("fa.addr+1", 1'b1, 1'b1, 1'b0);
    drive(1'b1, 1'b0, 4'b0000, 32'h0);
    tick();
    ctl("fa.data", 1'b1, 1'b1, 1'b0);
    tick();
    ctl("fa.data2", 1'b1, 1'b1, 1'b0);
    bus_idle();

    // Foreign transaction: unsupported command in range
    drive(1'b0, 1'b1, 4'b0010, 32'h0000_1008);
    tick();
    ctl("fc.addr+1", 1'b1, 1'b1, 1'b0);
    drive(1'b1, 1'b0, 4'b0000, 32'h0);
    tick();
    ctl("fc.data", 1'b1, 1'b1, 1'b0);
    bus_idle();

    // Reset during a burst read
    drive(1'b0, 1'b1, 4'b0110, 32'h0000_1038);
    tick();
    drive(1'b0, 1'b0, 4'b0000, 32'h0);
    tick();
    ctl("rst.pre", 1'b0, 1'b0, 1'b1);
    rst_n = 1'b0;
    #2;
    ctl("rst.async", 1'b1, 1'b1, 1'b0);
    drive(1'b1, 1'b1, 4'hF, 32'h0);
    rst_n = 1'b1;
    tick();

    // Single read of word 1 after reset
    drive(1'b0, 1'b1, 4'b0110, 32'h0000_1004);
    tick();
    ctl("rd2.addr+1", 1'b0, 1'b1, 1'b1);
    drive(1'b1, 1'b0, 4'b0000, 32'h0);
    tick();
    ctl("rd2.addr+2", 1'b0, 1'b0, 1'b1);
    check("rd2.data", ad_out, 32'h4444_4444);
    tick();
    ctl("rd2.after", 1'b1, 1'b1, 1'b0);
    bus_idle();

    // Word 2 must be untouched by the wrapping burst
    drive(1'b0, 1'b1, 4'b0110, 32'h0000_1008);
    tick();
    drive(1'b1, 1'b0, 4'b0000, 32'h0);
    tick();
    check("rd3.data", ad_out, 32'hDEAD_BEEF);
    tick();
    bus_idle();

    $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
    $finish;
  end

endmodule
